uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 receive path inside uart_top.
- Generics: clock rate, baud rate, data width, parity mode and oversampling ratio.
- Adds majority-vote sampling, false-start rejection, parity/framing error reporting and a valid/ready output handshake with overrun detection.
- Sits between the board rx pin and the encoder's byte-stream input.

---
 rtl/uart_rx_param_if.sv | 24 ++
 rtl/uart_rx_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Character stream from uart_rx_param to its consumer.
// Handshake: a character moves when rx_valid && rx_ready on a rising clk edge;
// rx_data and the error flags stay stable while rx_valid && !rx_ready.
`timescale 1ns/1ps
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, false-start rejection, parity/framing flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  busy,
    output logic [2:0]            dbg_state,
    uart_rx_param_if.master       stream
);
    localparam int TICK_DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_A       = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_B       = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_V       = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rxs;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic                 tick, at_a, at_b, at_v, at_end;
    logic                 samp_a, samp_b, vote;
    logic [DATA_BITS-1:0] data_sr;
    logic [BW-1:0]        bit_cnt;
    logic                 par_bad, par_exp;
    logic                 start_det, shift_en, par_latch, complete, comp_ferr;
    logic                 pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Counters sit at zero in IDLE, so the first tick period starts at start detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == S_IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    assign tick   = (div_cnt == DIV_LAST);
    assign at_a   = tick && (tick_cnt == T_A);
    assign at_b   = tick && (tick_cnt == T_B);
    assign at_v   = tick && (tick_cnt == T_V);
    assign at_end = tick && (tick_cnt == T_END);
    assign vote   = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign par_exp = (PARITY == 1) ? ~(^data_sr) : ^data_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        par_latch  = 1'b0;
        complete   = 1'b0;
        comp_ferr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_next = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (at_v && vote) state_next = S_IDLE;
                else if (at_end)  state_next = S_DATA;
            end
            S_DATA: begin
                shift_en = at_v;
                if (at_end && (bit_cnt == BITS_LAST))
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                par_latch = at_v;
                if (at_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (at_v) begin
                    complete   = 1'b1;
                    comp_ferr  = ~vote;
                    state_next = vote ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            data_sr <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
        end else begin
            if (at_a) samp_a <= rxs;
            if (at_b) samp_b <= rxs;
            if (start_det) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end
            if (shift_en) begin
                data_sr <= {vote, data_sr[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_latch) par_bad <= (vote != par_exp);
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign pop       = stream.rx_valid && stream.rx_ready;

`ifdef UART_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, empty, wr;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle frees the slot, so the write into a full FIFO still lands.
    assign wr    = complete && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {par_bad, comp_ferr, data_sr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            stream.overrun <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count          <= count + CW'(wr) - CW'(pop);
            stream.overrun <= complete && full && !pop;
        end
    end

    assign stream.rx_valid = !empty;
    assign {stream.parity_err, stream.frame_err, stream.rx_data} = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream.rx_data    <= '0;
            stream.rx_valid   <= 1'b0;
            stream.parity_err <= 1'b0;
            stream.frame_err  <= 1'b0;
            stream.overrun    <= 1'b0;
        end else begin
            stream.overrun <= complete && stream.rx_valid && !pop;
            if (complete && (!stream.rx_valid || pop)) begin
                stream.rx_data    <= data_sr;
                stream.parity_err <= par_bad;
                stream.frame_err  <= comp_ferr;
                stream.rx_valid   <= 1'b1;
            end else if (pop) begin
                stream.rx_valid   <= 1'b0;
            end
        end
    end
`endif
endmodule
